dbus_issue: RTL and testbench

//   Memory-stage data-bus initiator: issues one load/store per instruction to the dcache bus,

---
 rtl/dbus_issue_pkg.sv | 51 +++++
 rtl/dbus_issue_store_align.sv | 37 +++
 rtl/dbus_issue.sv | 173 +++++++++++++++++
 tb/tb_dbus_issue.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_issue_pkg.sv
// Shared types for the memory-stage data-bus initiator.
//   msize_t      : access size encoding (B/H/W/D)
//   dbus_state_t : issue FSM states, also exported on the debug port
//   dbus_req_t   : request bundle as seen on the dcache bus
//   dbus_resp_t  : response bundle from the dcache bus
//   size_mask()  : low address bits that must be zero for a natural alignment
package dbus_issue_pkg;

  localparam int DBUS_XLEN   = 64;
  localparam int DBUS_ADDR_W = 64;
  localparam int DBUS_STRB_W = DBUS_XLEN / 8;

  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2,
    MSIZE_D = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } dbus_state_t;

  typedef struct packed {
    logic                   valid;
    logic                   write;
    logic [DBUS_ADDR_W-1:0] addr;
    msize_t                 size;
    logic [DBUS_STRB_W-1:0] strobe;
    logic [DBUS_XLEN-1:0]   wdata;
  } dbus_req_t;

  typedef struct packed {
    logic                 addr_ok;
    logic                 data_ok;
    logic [DBUS_XLEN-1:0] rdata;
  } dbus_resp_t;

  function automatic logic [2:0] size_mask(input msize_t sz);
    case (sz)
      MSIZE_B: size_mask = 3'b000;
      MSIZE_H: size_mask = 3'b001;
      MSIZE_W: size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/dbus_issue_store_align.sv
// Store lane alignment (purely combinational).
//   off_i    : byte offset within the doubleword (addr[2:0])
//   msize_i  : access size
//   wdata_i  : right-justified store data
//   strobe_o : byte-lane enables for the access
//   wdata_o  : store data shifted onto its byte lanes
module dbus_issue_store_align
  import dbus_issue_pkg::*;
#(
  parameter int XLEN  = DBUS_XLEN,
  parameter int SW    = XLEN / 8,
  parameter int OFF_W = $clog2(SW)
) (
  input  logic [OFF_W-1:0] off_i,
  input  msize_t           msize_i,
  input  logic [XLEN-1:0]  wdata_i,
  output logic [SW-1:0]    strobe_o,
  output logic [XLEN-1:0]  wdata_o
);

  logic [SW-1:0] base;

  always_comb begin
    base = '0;
    case (msize_i)
      MSIZE_B: base = SW'(1);
      MSIZE_H: base = SW'(3);
      MSIZE_W: base = SW'(15);
      default: base = '1;
    endcase
    // A doubleword is only ever issued aligned, so it always covers every lane.
    strobe_o = (msize_i == MSIZE_D) ? '1 : (base << off_i);
    // Upper bits of wdata_i fall off the top; the strobe says which lanes count.
    wdata_o  = wdata_i << {off_i, 3'b000};
  end

endmodule

// File: rtl/dbus_issue.sv
// Memory-stage data-bus initiator.
//   Issues one load/store per instruction, stalls the pipeline until the
//   response arrives and presents the raw 64-bit load doubleword on rdata.
//   Ports: clk/resetn; req_* from the memory stage; advance/flush from the
//   pipeline control; dreq_* request to the dcache bus; dresp_* response;
//   stall/rdata/misalign back to the pipeline; dbg_state exposes the FSM.
//
//   Handshake: dreq_valid rises with a request and stays high, with the
//   payload unchanged, until a cycle where dresp_addr_ok is seen (REQ state).
//   Data returns on dresp_data_ok, either in that same cycle or later (WAIT).
//   A request is never withdrawn; a flushed request drains and is discarded.
module dbus_issue
  import dbus_issue_pkg::*;
#(
  parameter int XLEN   = DBUS_XLEN,
  parameter int ADDR_W = DBUS_ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [1:0]        req_msize,
  input  logic              advance,
  input  logic              flush,
  output logic              dreq_valid,
  output logic              dreq_write,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [XLEN/8-1:0] dreq_strobe,
  output logic [XLEN-1:0]   dreq_wdata,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_rdata,
  output logic              stall,
  output logic [XLEN-1:0]   rdata,
  output logic              misalign,
  output dbus_state_t       dbg_state
);

  localparam int SW    = XLEN / 8;
  localparam int OFF_W = $clog2(SW);

  dbus_state_t       state_q;
  logic              flushed_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [SW-1:0]     strobe_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;

  logic [SW-1:0]     al_strobe;
  logic [XLEN-1:0]   al_wdata;
  logic [SW-1:0]     new_strobe;
  logic [XLEN-1:0]   new_wdata;
  logic              misalign_raw;
  logic              launch;
  logic              kill;

  dbus_issue_store_align #(.XLEN(XLEN)) u_align (
    .off_i   (req_addr[OFF_W-1:0]),
    .msize_i (msize_t'(req_msize)),
    .wdata_i (req_wdata),
    .strobe_o(al_strobe),
    .wdata_o (al_wdata)
  );

  assign misalign_raw = req_valid &&
                        ((req_addr[2:0] & size_mask(msize_t'(req_msize))) != 3'b000);
  // resetn gates launch so the request drops the instant reset asserts,
  // even while the pipeline keeps req_valid high.
  assign launch = resetn && (state_q == ST_IDLE) && req_valid && !misalign_raw && !flush;
  assign kill   = flush || flushed_q;

  assign new_strobe = req_write ? al_strobe : '1;
  assign new_wdata  = req_write ? al_wdata  : '0;

  // Launch cycle drives the bus straight from req_*; REQ replays the latched copy.
  always_comb begin
    dreq_valid  = 1'b0;
    dreq_write  = 1'b0;
    dreq_addr   = '0;
    dreq_size   = 2'b00;
    dreq_strobe = '0;
    dreq_wdata  = '0;
    if (state_q == ST_REQ) begin
      dreq_valid  = 1'b1;
      dreq_write  = write_q;
      dreq_addr   = addr_q;
      dreq_size   = size_q;
      dreq_strobe = strobe_q;
      dreq_wdata  = wdata_q;
    end else if (launch) begin
      dreq_valid  = 1'b1;
      dreq_write  = req_write;
      dreq_addr   = req_addr;
      dreq_size   = req_msize;
      dreq_strobe = new_strobe;
      dreq_wdata  = new_wdata;
    end
  end

  assign stall     = launch || (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign misalign  = (state_q == ST_IDLE) && misalign_raw;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      flushed_q <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      size_q    <= 2'b00;
      strobe_q  <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            state_q   <= ST_REQ;
            flushed_q <= 1'b0;
            write_q   <= req_write;
            addr_q    <= req_addr;
            size_q    <= req_msize;
            strobe_q  <= new_strobe;
            wdata_q   <= new_wdata;
          end
        end
        ST_REQ: begin
          if (flush) flushed_q <= 1'b1;
          if (dresp_addr_ok) begin
            if (dresp_data_ok) begin
              // A squashed instruction's data is dropped and HOLD is skipped.
              if (kill) begin
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_HOLD;
                rdata_q <= dresp_rdata;
              end
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (flush) flushed_q <= 1'b1;
          if (dresp_data_ok) begin
            if (kill) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_HOLD;
              rdata_q <= dresp_rdata;
            end
          end
        end
        default: begin
          // HOLD keeps the finished instruction from re-issuing while
          // some other stage has the pipeline frozen.
          if (advance || flush) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // A response with no transaction open means the bus and this block disagree.
  a_no_stray_data : assert property (@(posedge clk) disable iff (!resetn)
    !(dresp_data_ok && ((state_q == ST_IDLE) || (state_q == ST_HOLD))));

endmodule

// File: tb/tb_dbus_issue.sv
module tb_dbus_issue;
  import dbus_issue_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_msize = 2'b00;
  logic        advance = 1'b0, flush = 1'b0;
  logic        dreq_valid, dreq_write;
  logic [63:0] dreq_addr, dreq_wdata;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_addr_ok = 1'b0, dresp_data_ok = 1'b0;
  logic [63:0] dresp_rdata = '0;
  logic        stall, misalign;
  logic [63:0] rdata;
  dbus_state_t dbg_state;

  always #5 clk = ~clk;

  dbus_issue dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_msize(req_msize),
    .advance(advance), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_rdata(dresp_rdata),
    .stall(stall), .rdata(rdata), .misalign(misalign), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input dbus_state_t exp);
    check(name, 64'(dbg_state), 64'(exp));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rv;
    logic        wr;
    logic [1:0]  sz;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        ev;      // expect a bus request
    logic [7:0]  estrb;
    logic [63:0] ewdata;
    logic        emis;
    logic [63:0] rsp;     // data returned by the bus for this access
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 2'd0, 64'h3,     64'hAB,                  1'b1, 8'h08, 64'h0000_0000_AB00_0000, 1'b0, 64'h0};
    vecs[1]  = '{1'b1, 1'b1, 2'd1, 64'h106,   64'hBEEF,                1'b1, 8'hC0, 64'hBEEF_0000_0000_0000, 1'b0, 64'h0};
    vecs[2]  = '{1'b1, 1'b1, 2'd2, 64'h24,    64'h1234_5678,           1'b1, 8'hF0, 64'h1234_5678_0000_0000, 1'b0, 64'h0};
    vecs[3]  = '{1'b1, 1'b1, 2'd3, 64'h40,    64'h0123_4567_89AB_CDEF, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0};
    vecs[4]  = '{1'b1, 1'b1, 2'd0, 64'h5,     64'hFFFF_FFFF_FFFF_FF5A, 1'b1, 8'h20, 64'hFFFF_5A00_0000_0000, 1'b0, 64'h0};
    vecs[5]  = '{1'b1, 1'b0, 2'd2, 64'h1004,  64'hFFFF,                1'b1, 8'hFF, 64'h0,                   1'b0, 64'hCAFE_F00D_1234_5678};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 64'h7,     64'h0,                   1'b1, 8'hFF, 64'h0,                   1'b0, 64'h0102_0304_0506_0708};
    vecs[7]  = '{1'b1, 1'b1, 2'd2, 64'h1002,  64'h1,                   1'b0, 8'h00, 64'h0,                   1'b1, 64'h0};
    vecs[8]  = '{1'b1, 1'b0, 2'd1, 64'h3,     64'h0,                   1'b0, 8'h00, 64'h0,                   1'b1, 64'h0};
    vecs[9]  = '{1'b1, 1'b0, 2'd3, 64'h1004,  64'h0,                   1'b0, 8'h00, 64'h0,                   1'b1, 64'h0};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 64'h1,     64'h0,                   1'b0, 8'h00, 64'h0,                   1'b0, 64'h0};
    vecs[11] = '{1'b1, 1'b1, 2'd1, 64'h3E,    64'h1234_ABCD,           1'b1, 8'hC0, 64'hABCD_0000_0000_0000, 1'b0, 64'h0};
  end

  // ---------------- driver helpers ----------------
  task automatic drive_req(input logic rv, input logic wr, input logic [1:0] sz,
                           input logic [63:0] addr, input logic [63:0] wdata);
    req_valid = rv;
    req_write = wr;
    req_msize = sz;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  task automatic clear_req();
    drive_req(1'b0, 1'b0, 2'd0, 64'h0, 64'h0);
  endtask

  // ---------------- test ----------------
  int n_stall;
  int n_dv;
  int n_bad;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_state("reset_state", ST_IDLE);
    check("reset_dreq_valid", 64'(dreq_valid), 64'h0);
    check("reset_stall", 64'(stall), 64'h0);
    check("reset_misalign", 64'(misalign), 64'h0);
    check("reset_rdata", rdata, 64'h0);
    check("reset_dreq_addr", dreq_addr, 64'h0);
    check("reset_dreq_strobe", 64'(dreq_strobe), 64'h0);
    @(negedge clk);
    resetn = 1'b1;

    // table: launch, registered replay, single-cycle completion, retire
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_req(vecs[i].rv, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("v%0d_valid", i),    64'(dreq_valid),  64'(vecs[i].ev));
      check($sformatf("v%0d_write", i),    64'(dreq_write),  64'(vecs[i].ev & vecs[i].wr));
      check($sformatf("v%0d_addr", i),     dreq_addr,        vecs[i].ev ? vecs[i].addr : 64'h0);
      check($sformatf("v%0d_size", i),     64'(dreq_size),   vecs[i].ev ? 64'(vecs[i].sz) : 64'h0);
      check($sformatf("v%0d_strobe", i),   64'(dreq_strobe), 64'(vecs[i].estrb));
      check($sformatf("v%0d_wdata", i),    dreq_wdata,       vecs[i].ewdata);
      check($sformatf("v%0d_misalign", i), 64'(misalign),    64'(vecs[i].emis));
      check($sformatf("v%0d_stall", i),    64'(stall),       64'(vecs[i].ev));
      if (vecs[i].ev) begin
        // REQ: inputs scrambled, bus must replay the latched payload
        @(negedge clk);
        clear_req();
        #1;
        check_state($sformatf("v%0d_req_state", i), ST_REQ);
        check($sformatf("v%0d_req_valid", i),  64'(dreq_valid),  64'h1);
        check($sformatf("v%0d_req_addr", i),   dreq_addr,        vecs[i].addr);
        check($sformatf("v%0d_req_strobe", i), 64'(dreq_strobe), 64'(vecs[i].estrb));
        check($sformatf("v%0d_req_wdata", i),  dreq_wdata,       vecs[i].ewdata);
        check($sformatf("v%0d_req_stall", i),  64'(stall),       64'h1);
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_rdata   = vecs[i].rsp;
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_rdata   = 64'h0;
        #1;
        check_state($sformatf("v%0d_hold_state", i), ST_HOLD);
        check($sformatf("v%0d_hold_stall", i), 64'(stall),      64'h0);
        check($sformatf("v%0d_hold_valid", i), 64'(dreq_valid), 64'h0);
        if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), rdata, vecs[i].rsp);
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        #1;
        check_state($sformatf("v%0d_retire_state", i), ST_IDLE);
      end else begin
        @(negedge clk);
        clear_req();
        #1;
        check_state($sformatf("v%0d_noissue_state", i), ST_IDLE);
      end
    end

    // LD 0x1000: addr_ok two cycles after launch, data_ok five cycles after
    @(negedge clk);
    drive_req(1'b1, 1'b0, 2'd3, 64'h1000, 64'h0);
    n_stall = 0;
    n_dv    = 0;
    for (int k = 0; k < 6; k++) begin
      dresp_addr_ok = (k == 2);
      dresp_data_ok = (k == 5);
      dresp_rdata   = (k == 5) ? 64'h1122_3344_5566_7788 : 64'h0;
      #1;
      if (stall) n_stall++;
      if (dreq_valid) n_dv++;
      @(negedge clk);
    end
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_rdata   = 64'h0;
    #1;
    check("ld_stall_cycles", 64'(n_stall), 64'd6);
    check("ld_req_cycles", 64'(n_dv), 64'd3);
    check_state("ld_hold_state", ST_HOLD);
    check("ld_hold_stall", 64'(stall), 64'h0);
    check("ld_rdata", rdata, 64'h1122_3344_5566_7788);

    // HOLD with advance low for 3 cycles: instruction must not re-issue
    n_bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (dreq_valid || stall) n_bad++;
    end
    check("hold_no_reissue", 64'(n_bad), 64'd0);
    check_state("hold_still_hold", ST_HOLD);
    @(negedge clk);
    advance = 1'b1;
    clear_req();
    @(negedge clk);
    advance = 1'b0;
    #1;
    check_state("hold_advance_idle", ST_IDLE);
    check("hold_rdata_kept", rdata, 64'h1122_3344_5566_7788);

    // flush in WAIT: drain, no HOLD, rdata untouched
    @(negedge clk);
    drive_req(1'b1, 1'b0, 2'd3, 64'h2000, 64'h0);
    @(negedge clk);
    dresp_addr_ok = 1'b1;
    #1;
    check_state("fw_req_state", ST_REQ);
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    flush = 1'b1;
    clear_req();
    #1;
    check_state("fw_wait_state", ST_WAIT);
    @(negedge clk);
    flush = 1'b0;
    dresp_data_ok = 1'b1;
    dresp_rdata   = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    check("fw_wait_stall", 64'(stall), 64'h1);
    @(negedge clk);
    dresp_data_ok = 1'b0;
    dresp_rdata   = 64'h0;
    #1;
    check_state("fw_drain_idle", ST_IDLE);
    check("fw_rdata_unchanged", rdata, 64'h1122_3344_5566_7788);
    check("fw_stall", 64'(stall), 64'h0);

    // flush in IDLE: nothing issued
    @(negedge clk);
    drive_req(1'b1, 1'b1, 2'd2, 64'h300, 64'h55);
    flush = 1'b1;
    #1;
    check("fi_valid", 64'(dreq_valid), 64'h0);
    check("fi_stall", 64'(stall), 64'h0);
    @(negedge clk);
    flush = 1'b0;
    clear_req();
    #1;
    check_state("fi_state", ST_IDLE);

    // flush in HOLD returns to IDLE
    @(negedge clk);
    drive_req(1'b1, 1'b0, 2'd0, 64'h10, 64'h0);
    @(negedge clk);
    clear_req();
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_rdata   = 64'h55;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_rdata   = 64'h0;
    #1;
    check_state("fh_hold", ST_HOLD);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_state("fh_idle", ST_IDLE);
    check("fh_rdata", rdata, 64'h55);

    // LW 0x1002 held for several cycles: misalign, never a request
    @(negedge clk);
    drive_req(1'b1, 1'b0, 2'd2, 64'h1002, 64'h0);
    n_dv = 0;
    n_bad = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (dreq_valid || stall) n_dv++;
      if (!misalign) n_bad++;
      @(negedge clk);
    end
    check("mis_no_request", 64'(n_dv), 64'd0);
    check("mis_flag_held", 64'(n_bad), 64'd0);
    clear_req();

    // reset asserted in REQ: request and stall drop at once
    @(negedge clk);
    drive_req(1'b1, 1'b1, 2'd3, 64'h80, 64'h1111_2222_3333_4444);
    @(negedge clk);
    #1;
    check_state("rst_in_req", ST_REQ);
    check("rst_pre_valid", 64'(dreq_valid), 64'h1);
    #1;
    resetn = 1'b0;
    #1;
    check("rst_valid_drop", 64'(dreq_valid), 64'h0);
    check("rst_stall_drop", 64'(stall), 64'h0);
    check_state("rst_state", ST_IDLE);
    check("rst_rdata", rdata, 64'h0);
    @(negedge clk);
    clear_req();
    resetn = 1'b1;
    #1;
    check_state("rst_release_idle", ST_IDLE);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
